// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
// Read-side consumer for the multi-port shifting FIFO. When the local staging
// buffer is empty, or will be empty after the current edge, it pops the valid
// head-lane prefix of the FIFO in a single cycle. The staged entries are then
// serialised onto a one-lane valid/ready stream. The refill overlaps the last
// drain, so a continuously non-empty FIFO streams at one entry per cycle.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   flush      synchronous clear of the staging buffer
//   fifo_rd    FIFO head entries, lane 0 = oldest
//   fifo_v     FIFO lane valid, contiguous from lane 0
//   fifo_re    FIFO read enable per lane, polarity ACT (combinational)
//   out_valid  a staged entry is available
//   out_data   current staged entry (0 when nothing is staged)
//   out_ready  downstream accepts out_data this cycle
//   stg_cnt    number of entries currently staged (0..READ)
// -----------------------------------------------------------------------------
module fifo_reader #(
    parameter int   DATA = 64,
    parameter int   READ = 4,
    // Active level of fifo_re; 1'b0 means active-low, matching the FIFO default.
    parameter logic ACT  = 1'b0,
    localparam int  CNTW = $clog2(READ) + 1,
    localparam int  HW   = (READ > 1) ? $clog2(READ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [READ-1:0][DATA-1:0]  fifo_rd,
    input  logic [READ-1:0]            fifo_v,
    output logic [READ-1:0]            fifo_re,
    output logic                       out_valid,
    output logic [DATA-1:0]            out_data,
    input  logic                       out_ready,
    output logic [CNTW-1:0]            stg_cnt
);

    logic [READ-1:0][DATA-1:0] stg_r;
    logic [CNTW-1:0]           cnt_r;
    logic [HW-1:0]             head_r;

    logic [CNTW-1:0]           fetch_n_s;
    logic                      refill_s;
    logic                      xfer_s;

    // Length of the run of 1s starting at lane 0; lanes past the first 0 are
    // ignored even if set, so a malformed valid vector never over-reads.
    function automatic logic [CNTW-1:0] lead_ones(input logic [READ-1:0] v);
        logic [CNTW-1:0] n;
        logic            run;
        n   = {CNTW{1'b0}};
        run = 1'b1;
        for (int i = 0; i < READ; i++) begin
            if (run && v[i]) begin
                n = n + CNTW'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    // Output view of the staging registers.
    always_comb begin
        out_valid = (cnt_r != {CNTW{1'b0}});
        stg_cnt   = cnt_r;
        if (out_valid) begin
            out_data = stg_r[head_r];
        end else begin
            out_data = {DATA{1'b0}};
        end
    end

    // Refill decision and FIFO pop vector; the FIFO pops in the same cycle.
    always_comb begin
        fetch_n_s = lead_ones(fifo_v);
        xfer_s    = out_valid && out_ready;
        // Staging is empty now, or its last entry leaves at this edge.
        refill_s  = !flush && ((cnt_r == {CNTW{1'b0}}) ||
                               ((cnt_r == CNTW'(1)) && out_ready));
        for (int i = 0; i < READ; i++) begin
            if (refill_s && !reset && (CNTW'(i) < fetch_n_s)) begin
                fifo_re[i] = ACT;
            end else begin
                fifo_re[i] = ~ACT;
            end
        end
    end

    // Staging state: flush beats refill, refill beats a plain drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= {CNTW{1'b0}};
            head_r <= {HW{1'b0}};
            stg_r  <= {(READ*DATA){1'b0}};
        end else if (flush) begin
            // Stale stg contents stay but are masked by out_data gating.
            cnt_r  <= {CNTW{1'b0}};
            head_r <= {HW{1'b0}};
        end else if (refill_s) begin
            // Covers fetch_n_s == 0 too: staging simply ends up empty.
            cnt_r  <= fetch_n_s;
            head_r <= {HW{1'b0}};
            for (int i = 0; i < READ; i++) begin
                if (CNTW'(i) < fetch_n_s) begin
                    stg_r[i] <= fifo_rd[i];
                end
            end
        end else if (xfer_s) begin
            cnt_r  <= cnt_r - CNTW'(1);
            head_r <= head_r + HW'(1);
        end else begin
            cnt_r  <= cnt_r;
            head_r <= head_r;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
// Directed and randomised stimulus for fifo_reader. The reference model keeps
// the upstream FIFO and the staging buffer as plain queues and applies the
// reader's rules (refill when empty / about to empty, pop the valid prefix,
// drain one per accepted cycle, flush/reset empty the stage).
// -----------------------------------------------------------------------------
module tb_fifo_reader;

    localparam int DATA = 64;
    localparam int READ = 4;

    logic                      clk;
    logic                      reset;
    logic                      flush;
    logic [READ-1:0][DATA-1:0] fifo_rd;
    logic [READ-1:0]           fifo_v;
    logic [READ-1:0]           fifo_re;
    logic                      out_valid;
    logic [DATA-1:0]           out_data;
    logic                      out_ready;
    logic [2:0]                stg_cnt;

    int tests = 0;
    int fails = 0;

    logic [DATA-1:0] fifoq[$];
    logic [DATA-1:0] sq[$];

    fifo_reader #(.DATA(DATA), .READ(READ), .ACT(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .fifo_rd   (fifo_rd),
        .fifo_v    (fifo_v),
        .fifo_re   (fifo_re),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stg_cnt   (stg_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present the FIFO model's head on the read port, optionally corrupting
    // the valid vector with a mask to create non-contiguous patterns.
    task automatic drive(input logic [3:0] vmask);
        int k;
        k = (fifoq.size() > READ) ? READ : fifoq.size();
        fifo_v = 4'b0000;
        for (int i = 0; i < READ; i++) begin
            if (i < k) begin
                fifo_v[i]  = 1'b1;
                fifo_rd[i] = fifoq[i];
            end else begin
                fifo_rd[i] = {$urandom, $urandom};
            end
        end
        fifo_v = fifo_v & vmask;
    endtask

    // One clock cycle: apply inputs, compare against the model, advance model.
    task automatic step(input bit rdy, input bit fl, input logic [3:0] vmask);
        int          n;
        bit          refill;
        bit          ev;
        logic [63:0] ed;
        logic [3:0]  ere;
        out_ready = rdy;
        flush     = fl;
        drive(vmask);
        if (reset) sq.delete();
        #1;
        n = 0;
        while (n < READ && fifo_v[n]) n++;
        ev     = (sq.size() != 0);
        ed     = ev ? sq[0] : 64'd0;
        refill = !fl && !reset && (sq.size() == 0 || (sq.size() == 1 && rdy));
        ere    = 4'b1111;
        for (int i = 0; i < n; i++) if (refill) ere[i] = 1'b0;
        check("out_valid", {63'd0, out_valid}, {63'd0, ev});
        check("out_data", out_data, ed);
        check("stg_cnt", {61'd0, stg_cnt}, 64'(sq.size()));
        check("fifo_re", {60'd0, fifo_re}, {60'd0, ere});
        check("inv_re_subset_v", {63'd0, ((~fifo_re) & ~fifo_v) == 4'b0000}, 64'd1);
        check("inv_re_idle_cnt_gt1", {63'd0, (stg_cnt > 3'd1) && (fifo_re != 4'b1111)}, 64'd0);
        check("inv_cnt_le_read", {63'd0, stg_cnt <= 3'd4}, 64'd1);
        if (reset) begin
            sq.delete();
        end else if (fl) begin
            sq.delete();
        end else if (refill) begin
            sq.delete();
            for (int i = 0; i < n; i++) sq.push_back(fifoq.pop_front());
        end else if (ev && rdy) begin
            void'(sq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (sq.size() == 0 && fifoq.size() == 0) break;
            step(1'b1, 1'b0, 4'b1111);
        end
        check("drain_bound", 64'(sq.size() + fifoq.size()), 64'd0);
        step(1'b1, 1'b0, 4'b1111);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        fifo_v    = 4'b0000;
        fifo_rd   = '0;
        #1;
        // Asynchronous reset, before any clock edge.
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_stg_cnt", {61'd0, stg_cnt}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_fifo_re", {60'd0, fifo_re}, 64'hF);
        repeat (3) @(posedge clk);
        #1;
        fifo_v = 4'b1111;
        #1;
        check("rst_re_with_valid", {60'd0, fifo_re}, 64'hF);
        check("rst_hold_cnt", {61'd0, stg_cnt}, 64'd0);
        fifo_v = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 4'b1111);

        // Single entry.
        fifoq.push_back(64'hA5);
        step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);

        // Back-to-back burst of 8.
        for (int i = 1; i <= 8; i++) fifoq.push_back(64'(i));
        repeat (10) step(1'b1, 1'b0, 4'b1111);

        // Backpressure with head = 1 and more data waiting upstream.
        for (int i = 10; i <= 13; i++) fifoq.push_back(64'(i));
        step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        for (int i = 14; i <= 17; i++) fifoq.push_back(64'(i));
        repeat (5) step(1'b0, 1'b0, 4'b1111);
        drain();

        // Non-contiguous valid with the reader idle.
        for (int i = 20; i <= 23; i++) fifoq.push_back(64'(i));
        step(1'b0, 1'b0, 4'b1011);
        check("noncontig_cnt", {61'd0, stg_cnt}, 64'd2);
        drain();

        // Flush mid-burst with three entries staged.
        for (int i = 30; i <= 37; i++) fifoq.push_back(64'(i));
        step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        drain();

        // Asynchronous reset mid-burst.
        for (int i = 40; i <= 45; i++) fifoq.push_back(64'(i));
        step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b0, 4'b1111);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 4'b1111);
        reset = 1'b0;
        drain();

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            logic [3:0] vm;
            if ($urandom_range(0, 3) == 0 && fifoq.size() < 16) begin
                int k;
                k = $urandom_range(1, 4);
                for (int j = 0; j < k; j++) fifoq.push_back({$urandom, $urandom});
            end
            vm = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b1111;
            reset = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, vm);
        end
        reset = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
